pong_frame_engine: RTL and testbench

Game-state and pixel-colour stage that sits directly downstream of the CRT timing controller in the Pong design. It consumes the controller's synchronized `xpos`/`ypos` coordinates and `vsync`. Once per video frame it updates the ball, both paddles and the scores. Every clock it produces a registered 8-bit RGB colour for the pixel currently being scanned.

---
 rtl/pong_frame_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_pong_frame_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : pong_frame_engine
// Purpose  : Per-frame Pong game state (ball, paddles, scores) plus the
//            registered 8-bit RGB colour of the pixel being scanned.
// Revision : 1.0 - initial release
// ============================================================================
module pong_frame_engine #(
  parameter int ResolutionSize  = 10,
  parameter int Xresolution     = 640,
  parameter int Yresolution     = 480,
  parameter int BallSize        = 8,
  parameter int BallSpeed       = 2,
  parameter int PaddleWidth     = 8,
  parameter int PaddleHeight    = 64,
  parameter int PaddleSpeed     = 4,
  parameter int LeftPaddleX     = 16,
  parameter int RightPaddleX    = 616,
  parameter int WinScore        = 9,
  parameter int PointHoldFrames = 60
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [ResolutionSize-1:0] xpos,
  input  logic [ResolutionSize-1:0] ypos,
  input  logic                      vsync,
  input  logic                      LeftUp,
  input  logic                      LeftDown,
  input  logic                      RightUp,
  input  logic                      RightDown,
  input  logic                      Serve,
  output logic [2:0]                red,
  output logic [2:0]                green,
  output logic [1:0]                blue,
  output logic [3:0]                LeftScore,
  output logic [3:0]                RightScore,
  output logic [1:0]                GameState
);

  // One extra bit of headroom so position sums never wrap.
  localparam int W  = ResolutionSize + 1;
  localparam int CW = $clog2(PointHoldFrames + 1);

  localparam logic [W-1:0]  c_xres      = W'(Xresolution);
  localparam logic [W-1:0]  c_yres      = W'(Yresolution);
  localparam logic [W-1:0]  c_ball      = W'(BallSize);
  localparam logic [W-1:0]  c_bspd      = W'(BallSpeed);
  localparam logic [W-1:0]  c_ph        = W'(PaddleHeight);
  localparam logic [W-1:0]  c_pspd      = W'(PaddleSpeed);
  localparam logic [W-1:0]  c_lpx       = W'(LeftPaddleX);
  localparam logic [W-1:0]  c_lpx_edge  = W'(LeftPaddleX + PaddleWidth);
  localparam logic [W-1:0]  c_rpx       = W'(RightPaddleX);
  localparam logic [W-1:0]  c_rpx_end   = W'(RightPaddleX + PaddleWidth);
  localparam logic [W-1:0]  c_pad_max   = W'(Yresolution - PaddleHeight);
  localparam logic [W-1:0]  c_pad_init  = W'((Yresolution - PaddleHeight) / 2);
  localparam logic [W-1:0]  c_ctr_x     = W'((Xresolution - BallSize) / 2);
  localparam logic [W-1:0]  c_ctr_y     = W'((Yresolution - BallSize) / 2);
  localparam logic [W-1:0]  c_line0     = W'(Xresolution / 2 - 1);
  localparam logic [W-1:0]  c_line1     = W'(Xresolution / 2);
  localparam logic [3:0]    c_win       = 4'(WinScore);
  localparam logic [CW-1:0] c_hold_last = CW'(PointHoldFrames - 1);

  typedef enum logic [1:0] {
    s_idle     = 2'd0,
    s_play     = 2'd1,
    s_point    = 2'd2,
    s_gameover = 2'd3
  } state_t;

  state_t         r_state;
  logic           r_vsync_d;
  logic           r_serve;
  logic [W-1:0]   r_bx, r_by;
  logic           r_dx;          // 1 = moving right
  logic           r_dy;          // 1 = moving down
  logic [W-1:0]   r_lpad, r_rpad;
  logic [3:0]     r_lscore, r_rscore;
  logic [CW-1:0]  r_hold;
  logic [7:0]     r_rgb;

  logic           w_tick;
  logic           w_lhit, w_rhit, w_lmiss, w_rmiss;
  logic [W-1:0]   w_px, w_py;
  logic           w_active, w_in_ball, w_in_lpad, w_in_rpad, w_in_line;

  // Paddle step with clamping; opposing buttons cancel.
  function automatic logic [W-1:0] pad_next(input logic [W-1:0] y,
                                            input logic up, input logic dn);
    logic [W-1:0] n;
    n = y;
    if (up && !dn)
      n = (y < c_pspd) ? '0 : y - c_pspd;
    else if (dn && !up)
      n = (y + c_pspd > c_pad_max) ? c_pad_max : y + c_pspd;
    return n;
  endfunction

  // Vertical overlap between the ball and a paddle.
  function automatic logic overlap(input logic [W-1:0] by, input logic [W-1:0] py);
    return (by + c_ball > py) && (by < py + c_ph);
  endfunction

  assign w_tick  = r_vsync_d & ~vsync;

  assign w_lhit  = !r_dx && (r_bx <= c_lpx_edge + c_bspd) && (r_bx >= c_lpx_edge)
                   && overlap(r_by, r_lpad);
  assign w_rhit  = r_dx && (r_bx + c_ball + c_bspd >= c_rpx) && (r_bx + c_ball <= c_rpx)
                   && overlap(r_by, r_rpad);
  assign w_lmiss = !r_dx && (r_bx < c_bspd);
  assign w_rmiss = (r_bx + c_ball + c_bspd > c_xres);

  assign w_px      = {1'b0, xpos};
  assign w_py      = {1'b0, ypos};
  assign w_active  = (w_px < c_xres) && (w_py < c_yres);
  assign w_in_ball = (w_px >= r_bx) && (w_px < r_bx + c_ball) &&
                     (w_py >= r_by) && (w_py < r_by + c_ball);
  assign w_in_lpad = (w_px >= c_lpx) && (w_px < c_lpx_edge) &&
                     (w_py >= r_lpad) && (w_py < r_lpad + c_ph);
  assign w_in_rpad = (w_px >= c_rpx) && (w_px < c_rpx_end) &&
                     (w_py >= r_rpad) && (w_py < r_rpad + c_ph);
  assign w_in_line = ((w_px == c_line0) || (w_px == c_line1)) && !ypos[3];

  // Frame-tick detection, serve latch, paddles, ball and score state machine.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= s_idle;
      r_vsync_d <= 1'b1;
      r_serve   <= 1'b0;
      r_bx      <= c_ctr_x;
      r_by      <= c_ctr_y;
      r_dx      <= 1'b1;
      r_dy      <= 1'b1;
      r_lpad    <= c_pad_init;
      r_rpad    <= c_pad_init;
      r_lscore  <= '0;
      r_rscore  <= '0;
      r_hold    <= '0;
    end else begin
      r_vsync_d <= vsync;
      if (w_tick)
        r_serve <= 1'b0;
      else if (Serve)
        r_serve <= 1'b1;

      if (w_tick) begin
        r_lpad <= pad_next(r_lpad, LeftUp, LeftDown);
        r_rpad <= pad_next(r_rpad, RightUp, RightDown);

        case (r_state)
          s_idle: begin
            r_bx <= c_ctr_x;
            r_by <= c_ctr_y;
            if (r_serve)
              r_state <= s_play;
          end

          s_play: begin
            // Vertical wall bounce is independent of the horizontal rules.
            if (!r_dy && (r_by < c_bspd)) begin
              r_by <= '0;
              r_dy <= 1'b1;
            end else if (r_dy && (r_by + c_ball + c_bspd > c_yres)) begin
              r_by <= c_yres - c_ball;
              r_dy <= 1'b0;
            end else begin
              r_by <= r_dy ? r_by + c_bspd : r_by - c_bspd;
            end

            if (w_lhit) begin
              r_bx <= c_lpx_edge;
              r_dx <= 1'b1;
            end else if (w_rhit) begin
              r_bx <= c_rpx - c_ball;
              r_dx <= 1'b0;
            end else if (w_lmiss) begin
              // Loser serves next: ball keeps heading toward the left side.
              r_dx <= 1'b0;
              if (r_rscore < c_win)
                r_rscore <= r_rscore + 4'd1;
              r_state <= (r_rscore + 4'd1 == c_win) ? s_gameover : s_point;
            end else if (w_rmiss) begin
              r_dx <= 1'b1;
              if (r_lscore < c_win)
                r_lscore <= r_lscore + 4'd1;
              r_state <= (r_lscore + 4'd1 == c_win) ? s_gameover : s_point;
            end else begin
              r_bx <= r_dx ? r_bx + c_bspd : r_bx - c_bspd;
            end
          end

          s_point: begin
            if (r_hold == c_hold_last) begin
              r_hold  <= '0;
              r_bx    <= c_ctr_x;
              r_by    <= c_ctr_y;
              r_state <= s_idle;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end

          s_gameover: begin
            if (r_serve) begin
              r_lscore <= '0;
              r_rscore <= '0;
              r_bx     <= c_ctr_x;
              r_by     <= c_ctr_y;
              r_state  <= s_idle;
            end
          end

          default: r_state <= s_idle;
        endcase
      end
    end
  end

  // Registered pixel colour, highest-priority object wins.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      r_rgb <= 8'h00;
    else if (!w_active)
      r_rgb <= 8'h00;
    else if (w_in_ball)
      r_rgb <= 8'hFF;
    else if (w_in_lpad)
      r_rgb <= 8'h1C;
    else if (w_in_rpad)
      r_rgb <= 8'h03;
    else if (w_in_line)
      r_rgb <= 8'h92;
    else
      r_rgb <= 8'h00;
  end

  assign red        = r_rgb[7:5];
  assign green      = r_rgb[4:2];
  assign blue       = r_rgb[1:0];
  assign LeftScore  = r_lscore;
  assign RightScore = r_rscore;
  assign GameState  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_frame_engine
// Purpose  : Directed self-checking bench for pong_frame_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_frame_engine;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [9:0] xpos  = '0;
  logic [9:0] ypos  = '0;
  logic       vsync = 1'b1;
  logic       LeftUp = 1'b0, LeftDown = 1'b0, RightUp = 1'b0, RightDown = 1'b0;
  logic       Serve = 1'b0;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic [3:0] LeftScore, RightScore;
  logic [1:0] GameState;

  int checks   = 0;
  int failures = 0;

  pong_frame_engine dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .xpos       (xpos),
    .ypos       (ypos),
    .vsync      (vsync),
    .LeftUp     (LeftUp),
    .LeftDown   (LeftDown),
    .RightUp    (RightUp),
    .RightDown  (RightDown),
    .Serve      (Serve),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .LeftScore  (LeftScore),
    .RightScore (RightScore),
    .GameState  (GameState)
  );

  // 100 MHz clock.
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One frame: vsync low for a single clock produces exactly one tick.
  task automatic frame();
    @(negedge Clock) vsync = 1'b0;
    @(negedge Clock) vsync = 1'b1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Serve pressed and released between ticks.
  task automatic press_serve();
    @(negedge Clock) Serve = 1'b1;
    @(negedge Clock) Serve = 1'b0;
  endtask

  // Colour registered for (x,y), one clock after presenting it.
  task automatic pix(input int x, input int y, output logic [7:0] c);
    @(negedge Clock);
    xpos = 10'(x);
    ypos = 10'(y);
    @(negedge Clock);
    c = {red, green, blue};
  endtask

  task automatic pix_check(input string tag, input int x, input int y, input logic [7:0] exp);
    logic [7:0] c;
    pix(x, y, c);
    check(tag, {24'd0, c}, {24'd0, exp});
  endtask

  // Ball top-left corner located at (x,y): inside corners white, outside not.
  task automatic ball_at(input string tag, input int x, input int y);
    logic [7:0] c;
    pix(x, y, c);
    check({tag, " tl"}, {24'd0, c}, 32'hFF);
    pix(x + 7, y + 7, c);
    check({tag, " br"}, {24'd0, c}, 32'hFF);
    pix(x - 1, y, c);
    check({tag, " left-out"}, {31'd0, c == 8'hFF}, 32'd0);
    if (y > 0) begin
      pix(x, y - 1, c);
      check({tag, " above-out"}, {31'd0, c == 8'hFF}, 32'd0);
    end
  endtask

  initial begin
    // Reset held: everything at reset values.
    repeat (3) @(negedge Clock);
    check("rst rgb", {24'd0, red, green, blue}, 32'd0);
    check("rst lscore", {28'd0, LeftScore}, 32'd0);
    check("rst rscore", {28'd0, RightScore}, 32'd0);
    check("rst state", {30'd0, GameState}, 32'd0);
    @(negedge Clock) Reset = 1'b1;

    // Idle frames with no input.
    frames(3);
    check("idle state", {30'd0, GameState}, 32'd0);
    ball_at("idle ball", 316, 236);
    pix_check("ball pix 318,240", 318, 240, 8'hFF);
    pix_check("outside x", 700, 10, 8'h00);
    pix_check("outside y", 10, 500, 8'h00);
    pix_check("lpad pix", 20, 220, 8'h1C);
    pix_check("lpad top", 16, 208, 8'h1C);
    pix_check("lpad above", 16, 207, 8'h00);
    pix_check("rpad pix", 620, 220, 8'h03);
    pix_check("rpad bottom", 623, 271, 8'h03);
    pix_check("rpad below", 623, 272, 8'h00);
    pix_check("cline 319,0", 319, 0, 8'h92);
    pix_check("cline gap 320,8", 320, 8, 8'h00);
    pix_check("cline 320,16", 320, 16, 8'h92);
    pix_check("cline 321", 321, 0, 8'h00);
    pix_check("black", 100, 100, 8'h00);
    pix_check("last active", 639, 479, 8'h00);

    // Left paddle: one step up, both buttons hold, then clamp at 0.
    LeftUp = 1'b1;
    frame();
    pix_check("lpad 204 top", 16, 204, 8'h1C);
    pix_check("lpad 204 above", 16, 203, 8'h00);
    LeftDown = 1'b1;
    frames(3);
    pix_check("both btn top", 16, 204, 8'h1C);
    pix_check("both btn above", 16, 203, 8'h00);
    LeftDown = 1'b0;
    frames(59);
    pix_check("lpad clamp top", 16, 0, 8'h1C);
    pix_check("lpad clamp end", 16, 63, 8'h1C);
    pix_check("lpad clamp below", 16, 64, 8'h00);
    LeftUp = 1'b0;

    // Nine rounds of right-side misses; paddle at 208 never meets the ball.
    for (int r = 1; r <= 9; r++) begin
      press_serve();
      frame();
      check("serve->play", {30'd0, GameState}, 32'd1);
      if (r == 1) begin
        frame();
        ball_at("play t1", 318, 238);
        frames(117);
        ball_at("play t118", 552, 472);
        frame();
        ball_at("bounce t119", 554, 472);
        frame();
        ball_at("after bounce t120", 556, 470);
        frames(39);
      end else begin
        frames(159);
      end
      check("lscore after miss", {28'd0, LeftScore}, 32'(r));
      check("rscore after miss", {28'd0, RightScore}, 32'd0);
      if (r < 9) begin
        check("point state", {30'd0, GameState}, 32'd2);
        frames(59);
        check("point hold 59", {30'd0, GameState}, 32'd2);
        frame();
        check("point->idle", {30'd0, GameState}, 32'd0);
        if (r == 1) ball_at("recentre", 316, 236);
      end else begin
        check("gameover state", {30'd0, GameState}, 32'd3);
      end
    end

    // Game over stays put without serve, then serve clears scores.
    frame();
    check("gameover hold", {30'd0, GameState}, 32'd3);
    check("gameover score held", {28'd0, LeftScore}, 32'd9);
    press_serve();
    frame();
    check("new game state", {30'd0, GameState}, 32'd0);
    check("new game lscore", {28'd0, LeftScore}, 32'd0);
    check("new game rscore", {28'd0, RightScore}, 32'd0);
    ball_at("new game ball", 316, 236);

    // Fresh reset, right paddle driven to its bottom clamp (416).
    @(negedge Clock) Reset = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    RightDown = 1'b1;
    frames(52);
    pix_check("rpad clamp top", 616, 416, 8'h03);
    pix_check("rpad clamp above", 616, 415, 8'h00);
    pix_check("rpad clamp end", 616, 479, 8'h03);

    // Ball meets the right paddle at x=606, y=420 on tick 146.
    press_serve();
    frame();
    frames(145);
    frame();
    ball_at("rhit", 608, 418);
    check("rhit state", {30'd0, GameState}, 32'd1);
    check("rhit lscore", {28'd0, LeftScore}, 32'd0);
    frame();
    ball_at("rhit moving left", 606, 416);

    // Asynchronous reset mid-frame during play.
    pix_check("pre-reset ball pix", 606, 416, 8'hFF);
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    check("async rst rgb", {24'd0, red, green, blue}, 32'd0);
    check("async rst state", {30'd0, GameState}, 32'd0);
    check("async rst lscore", {28'd0, LeftScore}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    RightDown = 1'b0;
    ball_at("post-reset ball", 316, 236);
    pix_check("post-reset rpad", 616, 208, 8'h03);
    frame();
    check("post-reset idle", {30'd0, GameState}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
